// File: rtl/tick_rate_controller.sv
// Tick rate controller.
// Generates a one-cycle tick enable whose period is set by the active rate mode
// (normal, fast, slow or error). The speed_up and slow_down controls are
// debounced before use. Mode changes take effect only at a tick boundary, so a
// period that has already started always runs to its full length.
module tick_rate_controller #(
  parameter int NORMAL_DIV = 8,
  parameter int FAST_DIV   = 4,
  parameter int SLOW_DIV   = 16,
  parameter int DEBOUNCE   = 3,
  parameter int CNT_W      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       slow_down,
  input  logic       speed_up,
  output logic       tick,
  output logic [1:0] mode,
  output logic       switching,
  output logic       error_code_2
);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_FAST   = 2'b01,
    MODE_SLOW   = 2'b10,
    MODE_ERROR  = 2'b11
  } mode_t;

  // Terminal counts. Each period runs cnt = 0 .. DIV-1.
  localparam logic [CNT_W-1:0] NORMAL_LAST = CNT_W'(NORMAL_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_LAST   = CNT_W'(FAST_DIV - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST   = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [CNT_W-1:0] su_cnt;
  logic [CNT_W-1:0] sd_cnt;
  logic             su_f;
  logic             sd_f;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_last;
  mode_t            active;
  mode_t            requested;

  // Debounce speed_up: accept a new level only after DEBOUNCE consecutive mismatches.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (reset) begin
      su_cnt <= '0;
      su_f   <= 1'b0;
    end else if (speed_up == su_f) begin
      su_cnt <= '0;
    end else if (su_cnt == DEB_LAST) begin
      su_f   <= speed_up;
      su_cnt <= '0;
    end else begin
      su_cnt <= su_cnt + CNT_ONE;
    end
  end

  // Debounce slow_down with the same rule as speed_up.
  always_ff @(posedge clock) begin
    if (reset) begin
      sd_cnt <= '0;
      sd_f   <= 1'b0;
    end else if (slow_down == sd_f) begin
      sd_cnt <= '0;
    end else if (sd_cnt == DEB_LAST) begin
      sd_f   <= slow_down;
      sd_cnt <= '0;
    end else begin
      sd_cnt <= sd_cnt + CNT_ONE;
    end
  end

  // Requested mode decoded from the filtered controls.
  // NOTE: a default assignment ahead of the case keeps this block free of
  // inferred latches even if a branch is later left incomplete.
  always_comb begin
    requested = MODE_NORMAL;
    case ({su_f, sd_f})
      2'b10:   requested = MODE_FAST;
      2'b01:   requested = MODE_SLOW;
      2'b11:   requested = MODE_ERROR;
      default: requested = MODE_NORMAL;
    endcase
  end

  // Terminal count of the period in progress, chosen by the active mode.
  always_comb begin
    div_last = NORMAL_LAST;
    case (active)
      MODE_FAST: div_last = FAST_LAST;
      MODE_SLOW: div_last = SLOW_LAST;
      default:   div_last = NORMAL_LAST;
    endcase
  end

  assign tick = (cnt == div_last);

  // Period counter and active mode. A pending request is adopted only on the
  // tick cycle, using the request as it stood before this edge's filter update.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      active <= MODE_NORMAL;
    end else if (tick) begin
      cnt    <= '0;
      active <= requested;
    end else begin
      cnt    <= cnt + CNT_ONE;
    end
  end

  // Registered conflict flag: both filtered controls asserted, updated every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      error_code_2 <= 1'b0;
    end else begin
      error_code_2 <= su_f & sd_f;
    end
  end

  assign mode      = active;
  assign switching = (requested != active);

endmodule

// File: tb/tb_tick_rate_controller.sv
// Testbench for tick_rate_controller.
// A cycle-level reference model predicts every output. The model tracks absolute
// tick times and run lengths rather than a wrapping counter. Directed scenarios
// add explicit checks on tick spacing and reset behaviour.
module tb_tick_rate_controller;

  localparam int NORMAL_DIV = 8;
  localparam int FAST_DIV   = 4;
  localparam int SLOW_DIV   = 16;
  localparam int DEBOUNCE   = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       slow_down = 1'b0;
  logic       speed_up = 1'b0;
  logic       tick;
  logic [1:0] mode;
  logic       switching;
  logic       error_code_2;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  int m_cyc, m_next_tick, m_pstart, m_mode, m_su_run, m_sd_run;
  bit m_su, m_sd, m_err;

  tick_rate_controller #(
    .NORMAL_DIV(NORMAL_DIV), .FAST_DIV(FAST_DIV), .SLOW_DIV(SLOW_DIV),
    .DEBOUNCE(DEBOUNCE), .CNT_W(16)
  ) dut (
    .clock(clock), .reset(reset), .slow_down(slow_down), .speed_up(speed_up),
    .tick(tick), .mode(mode), .switching(switching), .error_code_2(error_code_2)
  );

  always #5 clock = ~clock;

  function automatic int div_of(int md);
    case (md)
      1:       return FAST_DIV;
      2:       return SLOW_DIV;
      default: return NORMAL_DIV;
    endcase
  endfunction

  // bit0 = fast request, bit1 = slow request; both gives 3 (ERROR).
  function automatic int req_of(bit su, bit sd);
    return (sd ? 2 : 0) + (su ? 1 : 0);
  endfunction

  function automatic logic [4:0] expected();
    return {m_cyc == m_next_tick, 2'(m_mode), req_of(m_su, m_sd) != m_mode, m_err};
  endfunction

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_step();
    if (reset) begin
      m_cyc = 1; m_pstart = 1; m_next_tick = NORMAL_DIV; m_mode = 0;
      m_su = 1'b0; m_sd = 1'b0; m_su_run = 0; m_sd_run = 0; m_err = 1'b0;
    end else begin
      if (m_cyc == m_next_tick) begin
        m_mode      = req_of(m_su, m_sd);
        m_pstart    = m_cyc + 1;
        m_next_tick = m_cyc + div_of(m_mode);
      end
      m_err = m_su & m_sd;
      if (speed_up != m_su) begin
        m_su_run++;
        if (m_su_run == DEBOUNCE) begin m_su = speed_up; m_su_run = 0; end
      end else m_su_run = 0;
      if (slow_down != m_sd) begin
        m_sd_run++;
        if (m_sd_run == DEBOUNCE) begin m_sd = slow_down; m_sd_run = 0; end
      end else m_sd_run = 0;
      m_cyc++;
    end
  endtask

  // One clock: edge, model update, then settle before outputs are sampled.
  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; speed_up = 1'b0; slow_down = 1'b0;
    cycle(); cycle();
    vectors++;
    if ({tick, mode, switching, error_code_2} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %b required 00000", {tick, mode, switching, error_code_2});
    end
    reset = 1'b0;
    for (int n = 2; n <= 41; n++) begin
      cycle();
      vectors++;
      if ({tick, mode, switching, error_code_2} !== expected()) begin
        miscompares++;
        $display("FAIL reset_idle_model cyc=%0d: got %b required %b", n,
                 {tick, mode, switching, error_code_2}, expected());
      end
      vectors++;
      if ({tick, mode, switching, error_code_2} !== {n % 8 == 0, 4'b0000}) begin
        miscompares++;
        $display("FAIL reset_idle_tick cyc=%0d: got %b required %b", n,
                 {tick, mode, switching, error_code_2}, {n % 8 == 0, 4'b0000});
      end
    end
  endtask

  task automatic test_speed_up();
    int prev_tick = -1;
    int start_mode = 0;
    bit pending = 1'b0;
    cycle();  // now at count 1 of a NORMAL period
    speed_up = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      vectors++;
      if ({tick, mode, switching, error_code_2} !== expected()) begin
        miscompares++;
        $display("FAIL speed_up_model step=%0d: got %b required %b", i,
                 {tick, mode, switching, error_code_2}, expected());
      end
      if (tick) begin
        if (prev_tick >= 0) begin
          vectors++;
          if (i - prev_tick != div_of(start_mode)) begin
            miscompares++;
            $display("FAIL speed_up_spacing step=%0d: got %0d required %0d", i,
                     i - prev_tick, div_of(start_mode));
          end
        end
        prev_tick = i;
        pending = 1'b1;
      end else if (pending) begin
        start_mode = m_mode;
        pending = 1'b0;
      end
    end
    vectors++;
    if (mode !== 2'b01) begin
      miscompares++;
      $display("FAIL speed_up_final_mode: got %b required 01", mode);
    end
  endtask

  task automatic test_glitch();
    speed_up = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      vectors++;
      if ({tick, mode, switching, error_code_2} !== expected()) begin
        miscompares++;
        $display("FAIL glitch_settle_model step=%0d: got %b required %b", i,
                 {tick, mode, switching, error_code_2}, expected());
      end
    end
    speed_up = 1'b1;
    cycle(); cycle();
    speed_up = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      vectors++;
      if ({mode, switching} !== 3'b000 ||
          {tick, mode, switching, error_code_2} !== expected()) begin
        miscompares++;
        $display("FAIL glitch_ignored step=%0d: got %b required %b", i,
                 {tick, mode, switching, error_code_2}, expected());
      end
    end
  endtask

  task automatic test_both();
    bit saw_err = 1'b0;
    bit saw_error_mode = 1'b0;
    speed_up = 1'b1; slow_down = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 20) begin speed_up = 1'b0; slow_down = 1'b0; end
      cycle();
      if (error_code_2) saw_err = 1'b1;
      if (mode == 2'b11) saw_error_mode = 1'b1;
      vectors++;
      if ({tick, mode, switching, error_code_2} !== expected()) begin
        miscompares++;
        $display("FAIL both_model step=%0d: got %b required %b", i,
                 {tick, mode, switching, error_code_2}, expected());
      end
    end
    vectors++;
    if ({saw_err, saw_error_mode, mode, error_code_2} !== 5'b11000) begin
      miscompares++;
      $display("FAIL both_summary: got err_seen=%b error_mode_seen=%b mode=%b err=%b required 1 1 00 0",
               saw_err, saw_error_mode, mode, error_code_2);
    end
  endtask

  task automatic test_fast_to_slow();
    bit reached = 1'b0;
    int prev_tick = -1;
    int start_mode = 0;
    bit pending = 1'b0;
    speed_up = 1'b1;
    for (int i = 0; i < 100 && !reached; i++) begin
      cycle();
      vectors++;
      if ({tick, mode, switching, error_code_2} !== expected()) begin
        miscompares++;
        $display("FAIL fast_entry_model step=%0d: got %b required %b", i,
                 {tick, mode, switching, error_code_2}, expected());
      end
      if (mode == 2'b01) reached = 1'b1;
    end
    vectors++;
    if (!reached) begin
      miscompares++;
      $display("FAIL fast_entry_timeout: got mode=%b required 01 within 100 cycles", mode);
    end
    cycle();
    speed_up = 1'b0; slow_down = 1'b1;
    for (int i = 0; i < 70; i++) begin
      cycle();
      vectors++;
      if ({tick, mode, switching, error_code_2} !== expected()) begin
        miscompares++;
        $display("FAIL fast_to_slow_model step=%0d: got %b required %b", i,
                 {tick, mode, switching, error_code_2}, expected());
      end
      if (tick) begin
        if (prev_tick >= 0) begin
          vectors++;
          if (i - prev_tick != div_of(start_mode) || i - prev_tick < FAST_DIV) begin
            miscompares++;
            $display("FAIL fast_to_slow_spacing step=%0d: got %0d required %0d", i,
                     i - prev_tick, div_of(start_mode));
          end
        end
        prev_tick = i;
        pending = 1'b1;
      end else if (pending) begin
        start_mode = m_mode;
        pending = 1'b0;
      end
    end
    vectors++;
    if (mode !== 2'b10) begin
      miscompares++;
      $display("FAIL fast_to_slow_final_mode: got %b required 10", mode);
    end
  endtask

  task automatic test_reset_mid_slow();
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle();
      vectors++;
      if ({tick, mode, switching, error_code_2} !== expected()) begin
        miscompares++;
        $display("FAIL mid_slow_model step=%0d: got %b required %b", i,
                 {tick, mode, switching, error_code_2}, expected());
      end
      if (m_mode == 2 && m_cyc - m_pstart == 5) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL mid_slow_timeout: got mode=%b required SLOW count 5 within 100 cycles", mode);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    vectors++;
    if ({tick, mode, switching, error_code_2} !== 5'b0) begin
      miscompares++;
      $display("FAIL mid_slow_reset_state: got %b required 00000",
               {tick, mode, switching, error_code_2});
    end
    for (int n = 2; n <= 10; n++) begin
      cycle();
      vectors++;
      if (tick !== (n == 8) || {tick, mode, switching, error_code_2} !== expected()) begin
        miscompares++;
        $display("FAIL mid_slow_first_tick cyc=%0d: got %b required %b tick=%b", n,
                 {tick, mode, switching, error_code_2}, expected(), n == 8);
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        speed_up  = 1'($urandom_range(0, 1));
        slow_down = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 14);
      end
      hold--;
      reset = ($urandom_range(0, 199) == 0);
      cycle();
      vectors++;
      if ({tick, mode, switching, error_code_2} !== expected()) begin
        miscompares++;
        $display("FAIL random_model step=%0d: got %b required %b", i,
                 {tick, mode, switching, error_code_2}, expected());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_speed_up();
    test_glitch();
    test_both();
    test_fast_to_slow();
    test_reset_mid_slow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
